reg_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one enable-register bank (a WIDTH-bit register built from enable/reset flip-flops) between NREQ requesters. Each cycle it selects at most one requester using a rotating priority pointer, handshakes with it, and drives the bank's write-enable, write-data and synchronous-clear controls one cycle later. It sits between the requesting datapath stages and the shared register, so the register itself stays a plain enable/reset storage element.

---
 rtl/reg_write_arbiter_pkg.sv | 10 +
 rtl/reg_write_arbiter_pick.sv | 30 +++
 rtl/reg_write_arbiter.sv | 89 ++++++++
 tb/tb_reg_write_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and types for the round-robin register-write arbiter.
package reg_write_arbiter_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned IDX_W     = $clog2(NREQ_DEF);

    typedef logic [IDX_W-1:0] grant_idx_t;

endpackage

// File: rtl/reg_write_arbiter_pick.sv
// Rotating-priority picker: first valid requester at or after ptr, wrapping mod NREQ.
module rr_priority_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_val,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] win,
    output logic             any_valid
);

    always_comb begin
        logic [IDX_W-1:0] idx;
        grant     = '0;
        win       = '0;
        any_valid = 1'b0;
        idx       = '0;
        // NREQ is a power of two, so IDX_W-bit overflow is the modulo wrap
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDX_W'(ptr + IDX_W'(k));
            if (!any_valid && req_val[idx]) begin
                any_valid = 1'b1;
                win       = idx;
            end
        end
        grant[win] = any_valid;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter driving write-enable / data / sync-clear of a shared enable-reset register.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_val,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_rdy,
    input  logic                     clr,
    input  logic                     hold,
    output logic                     wr_en,
    output logic [WIDTH-1:0]         wr_data,
    output logic                     wr_clr,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  pick_grant;
    logic [PW-1:0]    pick_win;
    logic             pick_any;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             wr_en_d, wr_clr_d;
    logic [WIDTH-1:0] wr_data_d;
    logic [PW-1:0]    grant_id_d;

    rr_priority_pick #(
        .NREQ  (NREQ),
        .IDX_W (PW)
    ) u_pick (
        .req_val   (req_val),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .win       (pick_win),
        .any_valid (pick_any)
    );

    // Clear outranks stall; both suppress grants, as does reset
    assign req_rdy = (rst && !clr && !hold) ? pick_grant : '0;
    assign accept  = pick_any && |(req_val & req_rdy);

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_win == PW'(i)) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        wr_en_d    = 1'b0;
        wr_clr_d   = 1'b0;
        wr_data_d  = wr_data;
        grant_id_d = grant_id;
        if (clr) begin
            wr_clr_d = 1'b1;
        end else if (accept) begin
            wr_en_d    = 1'b1;
            wr_data_d  = sel_data;
            grant_id_d = pick_win;
            ptr_d      = PW'(pick_win + PW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= '0;
            wr_en    <= 1'b0;
            wr_clr   <= 1'b0;
            wr_data  <= '0;
            grant_id <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wr_en    <= wr_en_d;
            wr_clr   <= wr_clr_d;
            wr_data  <= wr_data_d;
            grant_id <= grant_id_d;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: round-robin reference model feeding a write-event scoreboard.
module tb_reg_write_arbiter;
    import reg_write_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_val;
    logic [31:0] req_data;
    logic [3:0]  req_rdy;
    logic        clr;
    logic        hold;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_clr;
    logic [1:0]  grant_id;

    typedef struct {
        logic       en;
        logic       clr_o;
        logic [7:0] data;
        grant_idx_t gid;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         m_ptr;
    logic [7:0] m_data;
    grant_idx_t m_gid;
    logic [7:0] dat [4];

    reg_write_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_val  (req_val),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .clr      (clr),
        .hold     (hold),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_clr   (wr_clr),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_data = 8'h00;
        m_gid  = '0;
    endtask

    // Pop the write event predicted for the edge just taken and compare it
    task automatic compare_out();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL sb_empty observed=%0d expected=%0d", sb.size(), 1);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wr_en",    32'(wr_en),    32'(e.en));
            chk("wr_clr",   32'(wr_clr),   32'(e.clr_o));
            chk("wr_data",  32'(wr_data),  32'(e.data));
            chk("grant_id", 32'(grant_id), 32'(e.gid));
            chk("en_clr_excl", 32'(wr_en & wr_clr), 32'(0));
        end
    endtask

    // One cycle: drive, check combinational grant, predict, clock, check registered outputs
    task automatic step(input logic [3:0] vld, input logic c, input logic h);
        logic [3:0] er;
        exp_t       e;
        int         w;
        req_val  = vld;
        clr      = c;
        hold     = h;
        req_data = {dat[3], dat[2], dat[1], dat[0]};
        #1;
        er = 4'b0000;
        w  = -1;
        if (!c && !h) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (w < 0 && vld[j]) begin
                    w     = j;
                    er[j] = 1'b1;
                end
            end
        end
        chk("req_rdy", 32'(req_rdy), 32'(er));
        e.en    = 1'b0;
        e.clr_o = 1'b0;
        if (c) begin
            e.clr_o = 1'b1;
        end else if (w >= 0) begin
            e.en   = 1'b1;
            m_data = dat[w];
            m_gid  = grant_idx_t'(w);
            m_ptr  = (w + 1) % 4;
        end
        e.data = m_data;
        e.gid  = m_gid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dat[i] = 8'(8'h10 + i);
        rst      = 1'b0;
        req_val  = 4'b1111;
        req_data = {dat[3], dat[2], dat[1], dat[0]};
        clr      = 1'b0;
        hold     = 1'b0;
        model_reset();

        // Reset holds everything at zero even with all requests pending
        #1;
        chk("rst_rdy",   32'(req_rdy),  32'(0));
        chk("rst_wr_en", 32'(wr_en),    32'(0));
        chk("rst_data",  32'(wr_data),  32'(0));
        chk("rst_clr",   32'(wr_clr),   32'(0));
        chk("rst_gid",   32'(grant_id), 32'(0));
        @(posedge clk);
        #1;
        chk("rst_edge_wr_en", 32'(wr_en), 32'(0));
        rst = 1'b1;
        #1;
        chk("release_rdy", 32'(req_rdy), 32'(4'b0001));

        // Rotation: grants 0,1,2,3,0
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 1'b0);
        chk("rot_last_data", 32'(wr_data), 32'(8'h10));

        // Skip and wrap: set ptr to 3, then 0110 picks 1, then 2
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0110, 1'b0, 1'b0);
        chk("skip_gid", 32'(grant_id), 32'(1));
        step(4'b0110, 1'b0, 1'b0);
        chk("skip2_gid", 32'(grant_id), 32'(2));

        // Clear beats hold; pointer stays at 3
        step(4'b0001, 1'b1, 1'b1);
        chk("clr_wr_clr", 32'(wr_clr), 32'(1));
        step(4'b1111, 1'b0, 1'b0);
        chk("clr_ptr_kept", 32'(grant_id), 32'(3));

        // Stall for three cycles, then requester 3 goes through
        for (int i = 0; i < 3; i++) step(4'b1000, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b0);
        chk("hold_release_gid", 32'(grant_id), 32'(3));

        // Idle cycle, then new data values
        step(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) dat[i] = 8'(8'hA0 + 3 * i);
        step(4'b1010, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 1'b0);

        // Async reset mid-burst
        step(4'b1111, 1'b0, 1'b0);
        chk("burst_wr_en", 32'(wr_en), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("async_wr_en", 32'(wr_en),    32'(0));
        chk("async_data",  32'(wr_data),  32'(0));
        chk("async_gid",   32'(grant_id), 32'(0));
        chk("async_rdy",   32'(req_rdy),  32'(0));
        @(posedge clk);
        #1;
        chk("async_edge_wr_en", 32'(wr_en), 32'(0));
        rst = 1'b1;
        model_reset();
        step(4'b1111, 1'b0, 1'b0);
        chk("post_rst_gid", 32'(grant_id), 32'(0));
        step(4'b1111, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
